// File: rtl/pc_branch_unit.sv
// -----------------------------------------------------------------------------
// pc_branch_unit
// Program-counter and branch-resolution stage of the nRisc core. Sits right
// after the ALU, consumes its Zero flag and result, and picks the next PC
// from decoded branch / call / return / jump-register controls. A small
// circular return-address stack backs call/ret. A one-cycle flush is raised
// toward fetch/decode after every PC redirect.
//
// Ports:
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   stall        in   hold all state, ignore controls, clear flush
//   br_type      in   00 none, 01 beq, 10 bne, 11 unconditional jump
//   br_offset    in   signed PC-relative offset
//   jr           in   jump to alu_out
//   call         in   push pc+1, jump pc+br_offset
//   ret          in   pop return address into pc
//   Zero         in   ALU zero flag
//   alu_out      in   ALU result (jr target)
//   pc           out  registered program counter
//   flush        out  registered, high the cycle after a redirect
//   stack_empty  out  return stack holds no entries
//   stack_full   out  return stack holds STACK_DEPTH entries
//   stack_err    out  sticky overflow/underflow flag
// -----------------------------------------------------------------------------
module pc_branch_unit #(
  parameter int              PC_W        = 8,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC    = 8'h00
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            stall,
  input  logic [1:0]      br_type,
  input  logic [PC_W-1:0] br_offset,
  input  logic            jr,
  input  logic            call,
  input  logic            ret,
  input  logic            Zero,
  input  logic [PC_W-1:0] alu_out,
  output logic [PC_W-1:0] pc,
  output logic            flush,
  output logic            stack_empty,
  output logic            stack_full,
  output logic            stack_err
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(1'b0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

  logic [PC_W-1:0]  pc_r;
  logic             flush_r;
  logic             err_r;
  logic [PTR_W-1:0] ptr_r;    // next free slot; ptr_r-1 is the top entry
  logic [CNT_W-1:0] count_r;
  logic [PC_W-1:0]  stack_r [STACK_DEPTH];

  logic [PC_W-1:0]  pc_plus1_s;
  logic [PC_W-1:0]  pc_rel_s;
  logic [PC_W-1:0]  top_entry_s;
  logic             empty_s;
  logic             full_s;
  logic             taken_s;
  logic [PC_W-1:0]  next_pc_s;
  logic             push_s;
  logic             pop_s;
  logic             redirect_s;
  logic             err_set_s;

  // Operand widths match PC_W, so plain addition is modulo 2^PC_W and the
  // two's-complement offset behaves as sign-extended.
  assign pc_plus1_s  = pc_r + PC_ONE;
  assign pc_rel_s    = pc_r + br_offset;
  assign top_entry_s = stack_r[ptr_r - PTR_ONE];
  assign empty_s     = (count_r == CNT_ZERO);
  assign full_s      = (count_r == CNT_FULL);

  // Conditional-branch resolution from br_type and the ALU Zero flag.
  always_comb begin
    taken_s = 1'b0;
    case (br_type)
      2'b01:   taken_s = Zero;
      2'b10:   taken_s = ~Zero;
      2'b11:   taken_s = 1'b1;
      default: taken_s = 1'b0;
    endcase
  end

  // Next-PC selection with fixed priority ret > call > jr > branch > +1.
  always_comb begin
    next_pc_s  = pc_r;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    redirect_s = 1'b0;
    err_set_s  = 1'b0;
    if (stall) begin
      next_pc_s  = pc_r;
      redirect_s = 1'b0;
    end else if (ret) begin
      if (!empty_s) begin
        next_pc_s  = top_entry_s;
        pop_s      = 1'b1;
        redirect_s = 1'b1;
      end else begin
        // Underflow: fall through sequentially, no redirect.
        next_pc_s = pc_plus1_s;
        err_set_s = 1'b1;
      end
    end else if (call) begin
      next_pc_s  = pc_rel_s;
      push_s     = 1'b1;
      redirect_s = 1'b1;
      err_set_s  = full_s;
    end else if (jr) begin
      next_pc_s  = alu_out;
      redirect_s = 1'b1;
    end else if (taken_s) begin
      next_pc_s  = pc_rel_s;
      redirect_s = 1'b1;
    end else begin
      next_pc_s = pc_plus1_s;
    end
  end

  // PC, flush, sticky error and stack bookkeeping registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_r    <= RESET_PC;
      flush_r <= 1'b0;
      err_r   <= 1'b0;
      ptr_r   <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      pc_r    <= next_pc_s;
      flush_r <= redirect_s;
      if (err_set_s) begin
        err_r <= 1'b1;
      end
      if (push_s) begin
        // When full the pointer already sits on the oldest entry, so the
        // wrap-around write overwrites it and count saturates.
        ptr_r <= ptr_r + PTR_ONE;
        if (!full_s) begin
          count_r <= count_r + CNT_ONE;
        end
      end else if (pop_s) begin
        ptr_r   <= ptr_r - PTR_ONE;
        count_r <= count_r - CNT_ONE;
      end
    end
  end

  // Return-address storage; contents after reset are don't-care.
  always_ff @(posedge clock) begin
    if (push_s) begin
      stack_r[ptr_r] <= pc_plus1_s;
    end
  end

  assign pc          = pc_r;
  assign flush       = flush_r;
  assign stack_empty = empty_s;
  assign stack_full  = full_s;
  assign stack_err   = err_r;

endmodule
